// File: rtl/uart_cmd_loader_if.sv
// Byte-stream, memory-write and go-handoff signals of the UART command loader.
// Latency: none, wiring only.
// Backpressure: mem_ready stalls the write side; the byte side is consumed via rx_clear.
interface uart_cmd_loader_if;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_clear;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic        go_valid;
    logic [31:0] go_addr;
    logic        busy;
    logic        cmd_done;
    logic        cmd_err;

    // Loader side.
    modport master (
        input  rx_ready, rx_data, mem_ready,
        output rx_clear, mem_we, mem_addr, mem_wdata, mem_be,
               go_valid, go_addr, busy, cmd_done, cmd_err
    );

    // Environment side: receiver, memory sink and core.
    modport slave (
        output rx_ready, rx_data, mem_ready,
        input  rx_clear, mem_we, mem_addr, mem_wdata, mem_be,
               go_valid, go_addr, busy, cmd_done, cmd_err
    );
endinterface

// File: rtl/uart_cmd_loader.sv
// Parses 'D' (load) / 'G' (go) host commands from a UART byte stream; optional UART_CMD_TIMEOUT_EN adds an inter-byte timeout.
// Latency: byte consumed in its rx_ready cycle; write request, go_valid, cmd_done and cmd_err appear one cycle later.
// Backpressure: a pending write holds mem_* until mem_ready; no bytes are consumed while the write is outstanding.
module uart_cmd_loader #(
    parameter logic [7:0] OP_LOAD = 8'h44,
    parameter logic [7:0] OP_GO   = 8'h47
`ifdef UART_CMD_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 5_000_000
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_cmd_loader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        LEN   = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        GADDR = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  bcnt_q, bcnt_d;       // byte index within a 4-byte header field
    logic [31:0] sh_q, sh_d;           // LSB-first field assembly
    logic [31:0] base_q, base_d;
    logic [31:0] len_q, len_d;
    logic [31:0] k_q, k_d;             // payload bytes taken so far
    logic [31:0] wbuf_q, wbuf_d;
    logic [3:0]  be_q, be_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        go_valid_q, go_valid_d;
    logic [31:0] go_addr_q, go_addr_d;
    logic        cmd_done_q, cmd_done_d;
    logic        cmd_err_q, cmd_err_d;
`ifdef UART_CMD_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
`endif

    logic        accept;
    logic [31:0] sh_next;
    logic [31:0] k_inc;

    // Bytes are only taken in parsing states and never while reset is asserted.
    assign accept  = rst_n && bus.rx_ready &&
                     (state_q == IDLE || state_q == ADDR || state_q == LEN ||
                      state_q == DATA || state_q == GADDR);
    assign sh_next = {bus.rx_data, sh_q[31:8]};
    assign k_inc   = k_q + 32'd1;

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        sh_d        = sh_q;
        base_d      = base_q;
        len_d       = len_q;
        k_d         = k_q;
        wbuf_d      = wbuf_q;
        be_d        = be_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        go_addr_d   = go_addr_q;
        go_valid_d  = 1'b0;
        cmd_done_d  = 1'b0;
        cmd_err_d   = 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
        tmo_d       = 32'd0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    bcnt_d = 2'd0;
                    if (bus.rx_data == OP_LOAD)    state_d = ADDR;
                    else if (bus.rx_data == OP_GO) state_d = GADDR;
                    else                           cmd_err_d = 1'b1;
                end
            end
            ADDR: begin
                if (accept) begin
                    sh_d   = sh_next;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        base_d  = {sh_next[31:2], 2'b00};
                        state_d = LEN;
                    end
                end
            end
            LEN: begin
                if (accept) begin
                    sh_d   = sh_next;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        len_d = sh_next;
                        k_d   = 32'd0;
                        if (sh_next == 32'd0) begin
                            cmd_done_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    wbuf_d[{k_q[1:0], 3'b000} +: 8] = bus.rx_data;
                    be_d[k_q[1:0]]                  = 1'b1;
                    k_d                             = k_inc;
                    // Word full or payload exhausted: launch the write.
                    if (k_inc[1:0] == 2'd0 || k_inc == len_q) begin
                        mem_addr_d  = base_q + {k_q[31:2], 2'b00};
                        mem_wdata_d = wbuf_d;
                        mem_be_d    = be_d;
                        mem_we_d    = 1'b1;
                        state_d     = WRITE;
                    end
                end
            end
            WRITE: begin
                if (bus.mem_ready) begin
                    mem_we_d = 1'b0;
                    wbuf_d   = 32'd0;
                    be_d     = 4'd0;
                    if (k_q == len_q) begin
                        cmd_done_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            GADDR: begin
                if (accept) begin
                    sh_d   = sh_next;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        go_addr_d  = sh_next;
                        go_valid_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef UART_CMD_TIMEOUT_EN
        // Idle-byte watchdog; WRITE is excluded since the sink, not the host, is stalling.
        if ((state_q == ADDR || state_q == LEN || state_q == DATA || state_q == GADDR) && !accept) begin
            if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
                cmd_err_d = 1'b1;
                state_d   = IDLE;
                wbuf_d    = 32'd0;
                be_d      = 4'd0;
                bcnt_d    = 2'd0;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end
`endif
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bcnt_q      <= 2'd0;
            sh_q        <= 32'd0;
            base_q      <= 32'd0;
            len_q       <= 32'd0;
            k_q         <= 32'd0;
            wbuf_q      <= 32'd0;
            be_q        <= 4'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
            go_valid_q  <= 1'b0;
            go_addr_q   <= 32'd0;
            cmd_done_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
            tmo_q       <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            sh_q        <= sh_d;
            base_q      <= base_d;
            len_q       <= len_d;
            k_q         <= k_d;
            wbuf_q      <= wbuf_d;
            be_q        <= be_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            go_valid_q  <= go_valid_d;
            go_addr_q   <= go_addr_d;
            cmd_done_q  <= cmd_done_d;
            cmd_err_q   <= cmd_err_d;
`ifdef UART_CMD_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign bus.rx_clear  = accept;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.go_valid  = go_valid_q;
    assign bus.go_addr   = go_addr_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.cmd_done  = cmd_done_q;
    assign bus.cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_uart_cmd_loader.sv
// Directed bench for uart_cmd_loader: host byte streams in, write/go/done/err activity recorded and compared.
// Latency: n/a.
// Backpressure: mem_ready is driven per test to stall the write side.
module tb_uart_cmd_loader;

    logic clk;
    logic rst_n;
    uart_cmd_loader_if bus ();

    uart_cmd_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    logic [31:0] wq_be[$];
    int          done_cnt = 0;
    int          err_cnt  = 0;
    int          go_cnt   = 0;
    logic [31:0] go_seen  = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Record completed write handshakes and pulse outputs away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_we && bus.mem_ready) begin
                wq_addr.push_back(bus.mem_addr);
                wq_data.push_back(bus.mem_wdata);
                wq_be.push_back({28'd0, bus.mem_be});
            end
            if (bus.cmd_done) done_cnt++;
            if (bus.cmd_err)  err_cnt++;
            if (bus.go_valid) begin
                go_cnt++;
                go_seen = bus.go_addr;
            end
        end
    end

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        wq_be.delete();
        done_cnt = 0;
        err_cnt  = 0;
        go_cnt   = 0;
    endtask

    // Present one byte like the async receiver: held until rx_clear, then dropped.
    // Entered and left just after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        bit taken = 1'b0;
        int n = 0;
        bus.rx_ready = 1'b1;
        bus.rx_data  = b;
        while (!taken && n < 2000) begin
            @(negedge clk);
            if (bus.rx_clear) taken = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        bus.rx_ready = 1'b0;
        if (!taken) check("rx_take_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t;
            t = w >> (8 * i);
            send_byte(t[7:0]);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < 500);
        if (bus.busy) check("idle_timeout", 32'd1, 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] be);
        if (idx >= wq_addr.size()) begin
            check({tag, "_missing"}, wq_addr.size(), idx + 1);
        end else begin
            check({tag, "_addr"}, wq_addr[idx], a);
            check({tag, "_data"}, wq_data[idx], d);
            check({tag, "_be"},   wq_be[idx],   be);
        end
    endtask

    initial begin
        int          bad;
        int          stall_we_low;
        int          stall_clr;
        int          stall_moved;
        logic [31:0] a0;
        logic [31:0] d0;

        rst_n         = 1'b0;
        bus.rx_ready  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_clear",  {31'd0, bus.rx_clear}, 32'd0);
        check("rst_mem_we",    {31'd0, bus.mem_we},   32'd0);
        check("rst_mem_addr",  bus.mem_addr,          32'd0);
        check("rst_mem_wdata", bus.mem_wdata,         32'd0);
        check("rst_mem_be",    {28'd0, bus.mem_be},   32'd0);
        check("rst_go_valid",  {31'd0, bus.go_valid}, 32'd0);
        check("rst_go_addr",   bus.go_addr,           32'd0);
        check("rst_busy",      {31'd0, bus.busy},     32'd0);
        check("rst_done_err",  {30'd0, bus.cmd_done, bus.cmd_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Five-byte payload: one full word then a partial word.
        clear_log();
        send_byte(8'h44);
        send_word(32'h0000_0000);
        send_word(32'h0000_0005);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
        wait_idle();
        check("p5_nwr", wq_addr.size(), 32'd2);
        check_wr("p5_w0", 0, 32'h0000_0000, 32'h4433_2211, 32'hF);
        check_wr("p5_w1", 1, 32'h0000_0004, 32'h0000_0055, 32'h1);
        check("p5_done", done_cnt, 32'd1);
        check("p5_err",  err_cnt,  32'd0);

        // Unaligned base near the top of memory wraps to address 0.
        clear_log();
        send_byte(8'h44);
        send_word(32'hFFFF_FFFF);
        send_word(32'h0000_0008);
        for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i));
        wait_idle();
        check("wrap_nwr", wq_addr.size(), 32'd2);
        check_wr("wrap_w0", 0, 32'hFFFF_FFFC, 32'hA3A2_A1A0, 32'hF);
        check_wr("wrap_w1", 1, 32'h0000_0000, 32'hA7A6_A5A4, 32'hF);

        // Sink stalls the first write for 20 cycles while the next byte waits.
        clear_log();
        bus.mem_ready = 1'b0;
        send_byte(8'h44);
        send_word(32'h0000_0100);
        send_word(32'h0000_0008);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        bus.rx_ready = 1'b1;
        bus.rx_data  = 8'h05;
        stall_we_low = 0;
        stall_clr    = 0;
        stall_moved  = 0;
        @(negedge clk);
        a0 = bus.mem_addr;
        d0 = bus.mem_wdata;
        check("stall_addr", a0, 32'h0000_0100);
        check("stall_data", d0, 32'h0403_0201);
        for (int i = 0; i < 20; i++) begin
            if (!bus.mem_we) stall_we_low++;
            if (bus.rx_clear) stall_clr++;
            if (bus.mem_addr !== a0 || bus.mem_wdata !== d0 || bus.mem_be !== 4'hF) stall_moved++;
            if (i < 19) @(negedge clk);
        end
        check("stall_we_low_cycles", stall_we_low, 32'd0);
        check("stall_rx_clear_cycles", stall_clr, 32'd0);
        check("stall_bus_moved_cycles", stall_moved, 32'd0);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
        wait_idle();
        check("stall_nwr", wq_addr.size(), 32'd2);
        check_wr("stall_w0", 0, 32'h0000_0100, 32'h0403_0201, 32'hF);
        check_wr("stall_w1", 1, 32'h0000_0104, 32'h0807_0605, 32'hF);
        check("stall_done", done_cnt, 32'd1);

        // Unknown opcode, then a go command.
        clear_log();
        send_byte(8'h2E);
        wait_idle();
        check("bad_op_err", err_cnt, 32'd1);
        send_byte(8'h47);
        send_word(32'h8000_0000);
        wait_idle();
        check("go_cnt",  go_cnt,  32'd1);
        check("go_addr", go_seen, 32'h8000_0000);
        check("go_hold", bus.go_addr, 32'h8000_0000);
        check("go_err",  err_cnt, 32'd1);

        // Zero-length load.
        clear_log();
        send_byte(8'h44);
        send_word(32'h0000_1000);
        send_word(32'h0000_0000);
        wait_idle();
        check("len0_done", done_cnt, 32'd1);
        check("len0_nwr",  wq_addr.size(), 32'd0);

        // Reset while a write is pending, then a fresh command.
        clear_log();
        bus.mem_ready = 1'b0;
        send_byte(8'h44);
        send_word(32'h0000_0300);
        send_word(32'h0000_0008);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        @(negedge clk);
        check("pre_rst_we", {31'd0, bus.mem_we}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_we",   {31'd0, bus.mem_we}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy},   32'd0);
        check("mid_rst_addr", bus.mem_addr,        32'd0);
        check("mid_rst_be",   {28'd0, bus.mem_be}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        clear_log();
        send_byte(8'h44);
        send_word(32'h0000_0200);
        send_word(32'h0000_0004);
        send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
        wait_idle();
        check("post_rst_nwr", wq_addr.size(), 32'd1);
        check_wr("post_rst_w0", 0, 32'h0000_0200, 32'h0807_0605, 32'hF);
        check("post_rst_done", done_cnt, 32'd1);

        // Full 4 KiB load with the sink always ready.
        clear_log();
        send_byte(8'h44);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'h80);
        send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
        for (int i = 0; i < 4096; i++) send_byte(8'hFF);
        wait_idle();
        check("big_nwr", wq_addr.size(), 32'd1024);
        bad = 0;
        for (int i = 0; i < wq_addr.size(); i++) begin
            if (wq_addr[i] !== 32'h8010_0000 + 32'(4 * i) || wq_data[i] !== 32'hFFFF_FFFF ||
                wq_be[i] !== 32'hF) bad++;
        end
        check("big_bad_writes", bad, 32'd0);
        check_wr("big_first", 0, 32'h8010_0000, 32'hFFFF_FFFF, 32'hF);
        check_wr("big_last", 1023, 32'h8010_0FFC, 32'hFFFF_FFFF, 32'hF);
        check("big_done", done_cnt, 32'd1);
        check("big_err",  err_cnt,  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
